// File: rtl/tx_packet_fifo.sv
// tx_packet_fifo: packet FIFO between the minimum-size padding stage and the 100G MAC TX.
// Frames are normally forwarded only once complete (store-and-forward) so the MAC never sees a
// gap inside a frame. A frame too large to fit is streamed out as it arrives (cut-through).
//
// Ports:
//   CLK, RST_N                 clock (rising edge), synchronous active-low reset
//   S_AXIS_T{DATA,STRB,LAST,VALID,DEST,USER}, S_AXIS_TREADY   input stream
//   M_AXIS_T{DATA,STRB,LAST,VALID,DEST,USER}, M_AXIS_TREADY   registered output stream
//   STAT_PKT_COUNT, STAT_BYTE_COUNT   present only when TX_FIFO_STATS_EN is defined
//
// Optional build macro: TX_FIFO_STATS_EN adds transmitted packet/byte counters.

module tx_packet_fifo #(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [511:0]           S_AXIS_TDATA,
  input  logic [63:0]            S_AXIS_TSTRB,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  input  logic [TDEST_WIDTH-1:0] S_AXIS_TDEST,
  input  logic [TUSER_WIDTH-1:0] S_AXIS_TUSER,
  output logic                   S_AXIS_TREADY,
  output logic [511:0]           M_AXIS_TDATA,
  output logic [63:0]            M_AXIS_TSTRB,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  output logic [TDEST_WIDTH-1:0] M_AXIS_TDEST,
  output logic [TUSER_WIDTH-1:0] M_AXIS_TUSER,
  input  logic                   M_AXIS_TREADY
`ifdef TX_FIFO_STATS_EN
  ,
  output logic [31:0]            STAT_PKT_COUNT,
  output logic [47:0]            STAT_BYTE_COUNT
`endif
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned BeatW  = 512 + 64 + 1 + TDEST_WIDTH + TUSER_WIDTH;
  localparam int unsigned LastB  = 576;
  localparam int unsigned DestLo = 577;
  localparam int unsigned UserLo = 577 + TDEST_WIDTH;

  localparam logic [AW:0]   PtrOne   = (AW+1)'(1);
  localparam logic [AW+1:0] DepthVal = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStoreFwd, StCutThru} state_e;

  state_e state_q, state_d;

  logic [BeatW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      pkt_cnt_q, pkt_cnt_d;   // complete packets not yet fully sent
  logic [AW:0]      ram_pkt_q, ram_pkt_d;   // TLAST beats still held in the RAM
  logic [AW:0]      ram_cnt;
  logic [AW+1:0]    occupancy;

  logic [511:0]           m_tdata_q;
  logic [63:0]            m_tstrb_q;
  logic                   m_tlast_q, m_tvalid_q;
  logic [TDEST_WIDTH-1:0] m_tdest_q;
  logic [TUSER_WIDTH-1:0] m_tuser_q;

  logic [BeatW-1:0] wr_beat, rd_beat;
  logic wr_en, wr_last, rd_en, rd_last, m_hs, m_last_hs;
  logic empty, full, out_free, fetch_ok;

  assign wr_beat = {S_AXIS_TUSER, S_AXIS_TDEST, S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA};
  assign rd_beat = mem[rd_ptr_q[AW-1:0]];

  assign ram_cnt = wr_ptr_q - rd_ptr_q;
  // The output register counts as storage, so the RAM plus it never exceeds FIFO_DEPTH.
  assign occupancy = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, m_tvalid_q};

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign S_AXIS_TREADY = RST_N && (occupancy < DepthVal);
  assign wr_en         = S_AXIS_TVALID && S_AXIS_TREADY;
  assign wr_last       = wr_en && S_AXIS_TLAST;

  assign m_hs      = m_tvalid_q && M_AXIS_TREADY;
  assign m_last_hs = m_hs && m_tlast_q;
  assign out_free  = !m_tvalid_q || M_AXIS_TREADY;
  assign rd_en     = fetch_ok && !empty && out_free;
  assign rd_last   = rd_en && rd_beat[LastB];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (wr_last && !m_last_hs) begin
      pkt_cnt_d = pkt_cnt_q + PtrOne;
    end else if (!wr_last && m_last_hs) begin
      pkt_cnt_d = pkt_cnt_q - PtrOne;
    end
    ram_pkt_d = ram_pkt_q;
    if (wr_last && !rd_last) begin
      ram_pkt_d = ram_pkt_q + PtrOne;
    end else if (!wr_last && rd_last) begin
      ram_pkt_d = ram_pkt_q - PtrOne;
    end
  end

  always_comb begin
    state_d  = state_q;
    fetch_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pkt_cnt_q != '0) begin
          state_d = StStoreFwd;
        end else if (full) begin
          state_d = StCutThru;
        end
      end
      StStoreFwd: begin
        // Only pull beats of frames whose TLAST is already stored: output never starves mid-frame.
        fetch_ok = (ram_pkt_q != '0);
        if (m_last_hs && (pkt_cnt_d == '0)) begin
          state_d = StIdle;
        end
      end
      StCutThru: begin
        // Stop once the oversize frame's TLAST sits in the output register.
        fetch_ok = !(m_tvalid_q && m_tlast_q);
        if (m_last_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_beat;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      ram_pkt_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tdest_q  <= '0;
      m_tuser_q  <= '0;
    end else begin
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
      ram_pkt_q <= ram_pkt_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_en) begin
        rd_ptr_q   <= rd_ptr_q + PtrOne;
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= rd_beat[511:0];
        m_tstrb_q  <= rd_beat[575:512];
        m_tlast_q  <= rd_beat[LastB];
        m_tdest_q  <= rd_beat[DestLo +: TDEST_WIDTH];
        m_tuser_q  <= rd_beat[UserLo +: TUSER_WIDTH];
      end else if (m_hs) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TDATA  = m_tdata_q;
  assign M_AXIS_TSTRB  = m_tstrb_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDEST  = m_tdest_q;
  assign M_AXIS_TUSER  = m_tuser_q;

`ifdef TX_FIFO_STATS_EN
  logic [31:0] stat_pkt_q;
  logic [47:0] stat_byte_q;
  logic [47:0] pkt_bytes_q;   // bytes of the frame currently leaving, excluding this beat
  logic [47:0] beat_bytes;

  function automatic logic [6:0] popcnt64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  assign beat_bytes = {41'd0, popcnt64(m_tstrb_q)};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_pkt_q  <= '0;
      stat_byte_q <= '0;
      pkt_bytes_q <= '0;
    end else if (m_hs) begin
      if (m_tlast_q) begin
        stat_pkt_q  <= stat_pkt_q + 32'd1;
        stat_byte_q <= stat_byte_q + pkt_bytes_q + beat_bytes;
        pkt_bytes_q <= '0;
      end else begin
        pkt_bytes_q <= pkt_bytes_q + beat_bytes;
      end
    end
  end

  assign STAT_PKT_COUNT  = stat_pkt_q;
  assign STAT_BYTE_COUNT = stat_byte_q;
`endif

endmodule

// File: doc/tx_packet_fifo.md
TX_PACKET_FIFO -- requirements
Module: tx_packet_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, meaning storage depth in 512-bit beats (power of two, 16..1024).
REQ-002 SHALL have parameter TUSER_WIDTH, default 1, meaning sideband user width carried per beat.
REQ-003 SHALL have parameter TDEST_WIDTH, default 1, meaning sideband dest width carried per beat.
REQ-004 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports S_AXIS_TDATA/TSTRB/TLAST/TVALID/TDEST/TUSER  input  512/64/1/1/TDEST_WIDTH/TUSER_WIDTH  padded-frame stream from the minimum-size padding stage.
REQ-007 SHALL have port S_AXIS_TREADY  output  1  asserted when the FIFO can accept a beat.
REQ-008 SHALL have ports M_AXIS_TDATA/TSTRB/TLAST/TVALID/TDEST/TUSER  output  same widths  stream to the 100G MAC TX.
REQ-009 SHALL have port M_AXIS_TREADY  input  1  MAC backpressure.

Function
REQ-010 SHALL store all six S_AXIS fields per beat and replay them unmodified, in order, on M_AXIS.
REQ-011 SHALL assert S_AXIS_TREADY iff stored beats < FIFO_DEPTH and not in reset; acceptance = TVALID&TREADY.
REQ-012 SHALL keep pkt_cnt = number of complete packets (TLAST beat written) not yet fully read; +1 on TLAST write, -1 on TLAST read, unchanged on simultaneous both.
REQ-013 SHALL implement states IDLE, STORE_FWD, CUT_THRU; reset to IDLE.
REQ-014 IDLE->STORE_FWD when pkt_cnt>0; STORE_FWD->IDLE after the TLAST beat is read and pkt_cnt becomes 0; else stays STORE_FWD.
REQ-015 IDLE->CUT_THRU when FIFO full and pkt_cnt==0 (oversize packet); CUT_THRU->IDLE after its TLAST beat is read.
REQ-016 SHALL never deassert M_AXIS_TVALID between the first and TLAST beat of a packet in STORE_FWD (no MAC underrun).
REQ-017 In CUT_THRU, M_AXIS_TVALID SHALL follow FIFO non-empty; gaps permitted.
REQ-018 M_AXIS outputs SHALL be registered; M_AXIS_TVALID first rises 2 edges after the edge accepting a TLAST beat into an empty FIFO.
REQ-019 M_AXIS fields SHALL hold stable while TVALID=1 and TREADY=0.
REQ-020 Sustained throughput SHALL be 1 beat/cycle in and out simultaneously when neither full nor empty.
REQ-021 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty from MSB compare.
REQ-022 Simultaneous read and write when full SHALL be permitted only if TREADY was already high that cycle (no combinational TREADY from M_AXIS_TREADY).

Reset
REQ-023 RST_N=0 at an edge SHALL clear pointers, pkt_cnt, state=IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA/TSTRB/TDEST/TUSER=0.
REQ-024 S_AXIS_TREADY SHALL be 0 while RST_N=0 and 1 on the first cycle after release.
REQ-025 Reset mid-packet SHALL discard all stored beats, including partial packets; no partial frame emitted after release.

Configuration
REQ-026 Macro TX_FIFO_STATS_EN SHALL, when defined, add outputs STAT_PKT_COUNT (32b) and STAT_BYTE_COUNT (48b), cleared by reset, incremented on each M_AXIS TLAST handshake by 1 and by the packet's total set TSTRB bits respectively, wrapping at max.
REQ-027 Without TX_FIFO_STATS_EN the outputs and counters SHALL not exist; remaining behaviour identical.

Verification
REQ-028 One-beat 60B packet (TSTRB=0x0FFFFFFFFFFFFFFF, TLAST), M_TREADY=1 -> TVALID 2 edges later, data identical, pkt_cnt 1->0.
REQ-029 4-beat packet input with 1-cycle gaps between beats -> M_AXIS emits 4 consecutive TVALID beats with no gap.
REQ-030 FIFO_DEPTH=16, 20-beat packet, M_TREADY=1 -> CUT_THRU entered at full, all 20 beats delivered in order, state returns IDLE.
REQ-031 M_TREADY=0, write 16 beats -> S_AXIS_TREADY=0 at 16 stored; M_TREADY=1 -> drains, TREADY reasserts.
REQ-032 Reset after 2 beats of a 3-beat packet -> no M_AXIS_TVALID after release; next 1-beat packet delivered alone.
REQ-033 With TX_FIFO_STATS_EN, three packets of 60, 128, 1514 bytes -> STAT_PKT_COUNT=3, STAT_BYTE_COUNT=1702.
